// File: rtl/adc_seq_pkg.sv
// Shared types and sizing for the ADC sequencer: FSM states and the
// outstanding-command tag carried from command issue to response match.
package adc_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  // Tag fields are sized for the largest supported configuration
  localparam int SLOT_W      = 4;  // up to 16 slots
  localparam int CHAN_W      = 8;  // widest channel field accepted
  localparam int Q_DEPTH_MAX = 4;
  localparam int CNT_W       = 3;  // holds 0..Q_DEPTH_MAX

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [CHAN_W-1:0] channel;
  } tag_t;

endpackage

// File: rtl/adc_seq_tag_fifo.sv
// Small FIFO of expected {slot, channel} tags for commands awaiting a response.
// Push and pop may coincide, including when full.
module adc_seq_tag_fifo
  import adc_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  tag_t             wr_tag,
  output tag_t             rd_tag,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_tag  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_tag;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Avalon-ST command initiator / response collector for the MAX10 ADC sequencer
// core: walks a slot list, tracks outstanding commands, banks the latest samples.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_SLOTS       = 8,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CHANNEL_WIDTH   = 5,
  parameter int DATA_WIDTH      = 12
) (
  input  logic                               clock_clk,
  input  logic                               reset_sink_reset,
  input  logic                               enable,
  input  logic [NUM_SLOTS*CHANNEL_WIDTH-1:0] slot_channel,
  input  logic [$clog2(NUM_SLOTS):0]         slot_count,
  output logic                               command_valid,
  output logic [CHANNEL_WIDTH-1:0]           command_channel,
  output logic                               command_startofpacket,
  output logic                               command_endofpacket,
  input  logic                               command_ready,
  input  logic                               response_valid,
  input  logic [CHANNEL_WIDTH-1:0]           response_channel,
  input  logic [DATA_WIDTH-1:0]              response_data,
  input  logic                               response_startofpacket,
  input  logic                               response_endofpacket,
  input  logic [$clog2(NUM_SLOTS)-1:0]       rd_slot,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_fresh,
  output logic                               sample_valid,
  output logic [$clog2(NUM_SLOTS)-1:0]       sample_slot,
  output logic                               sequence_done,
  output logic                               channel_error,
  output logic                               protocol_error
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int NB = 2**SW;

  state_t                             state, state_nxt;
  logic [SW-1:0]                      ptr, last_slot;
  logic [SW:0]                        cnt_lat, cnt_in;
  logic [NUM_SLOTS*CHANNEL_WIDTH-1:0] chan_lat;
  logic [CHANNEL_WIDTH-1:0]           cmd_chan;
  logic                               start, xfer, is_last_ptr;

  tag_t             push_tag, head;
  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty, resp_pop, head_last;

  logic [DATA_WIDTH-1:0] bank [NB];
  logic [NB-1:0]         fresh;
  logic                  sop_unused;

  // SOP carries no information the tag queue doesn't already have
  assign sop_unused = response_startofpacket;

  always_comb begin
    cnt_in = slot_count;
    if (slot_count == '0) cnt_in = (SW+1)'(1);
    else if (slot_count > (SW+1)'(NUM_SLOTS)) cnt_in = (SW+1)'(NUM_SLOTS);
  end

  assign last_slot   = SW'(cnt_lat - 1'b1);
  assign is_last_ptr = (ptr == last_slot);
  assign cmd_chan    = chan_lat[ptr*CHANNEL_WIDTH +: CHANNEL_WIDTH];

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    command_valid = 1'b0;
    start         = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nxt = ISSUE;
        start     = 1'b1;
      end
      ISSUE: begin
        command_valid = !q_full;
        if (!q_full && command_ready && is_last_ptr) state_nxt = DRAIN;
      end
      DRAIN: if (q_count == '0) begin
        if (enable) begin
          state_nxt = ISSUE;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer                  = command_valid && command_ready;
  assign command_channel       = command_valid ? cmd_chan : '0;
  assign command_startofpacket = command_valid && (ptr == '0);
  assign command_endofpacket   = command_valid && is_last_ptr;

  // Slot list is snapshotted per sequence so mid-packet edits can't tear it
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      ptr      <= '0;
      cnt_lat  <= (SW+1)'(1);
      chan_lat <= '0;
    end else if (start) begin
      ptr      <= '0;
      cnt_lat  <= cnt_in;
      chan_lat <= slot_channel;
    end else if (xfer && !is_last_ptr) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign push_tag = {SLOT_W'(ptr), CHAN_W'(cmd_chan)};

  adc_seq_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk    (clock_clk),
    .rst    (reset_sink_reset),
    .push   (xfer),
    .pop    (resp_pop),
    .wr_tag (push_tag),
    .rd_tag (head),
    .count  (q_count),
    .full   (q_full),
    .empty  (q_empty)
  );

  assign resp_pop  = response_valid && !q_empty;
  assign head_last = (head.slot == SLOT_W'(last_slot));

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      sample_valid   <= 1'b0;
      sample_slot    <= '0;
      sequence_done  <= 1'b0;
      channel_error  <= 1'b0;
      protocol_error <= 1'b0;
      rd_data        <= '0;
      rd_fresh       <= 1'b0;
      fresh          <= '0;
      for (int k = 0; k < NB; k++) bank[k] <= '0;
    end else begin
      sample_valid  <= resp_pop;
      sequence_done <= resp_pop && head_last;
      if (resp_pop) sample_slot <= SW'(head.slot);
      if (response_valid && q_empty) protocol_error <= 1'b1;
      if (resp_pop && ((CHAN_W'(response_channel) != head.channel) ||
                       (response_endofpacket && !head_last)))
        channel_error <= 1'b1;
      rd_data  <= bank[rd_slot];
      rd_fresh <= fresh[rd_slot];
      // A same-cycle write beats the read-clear so no update is lost
      for (int k = 0; k < NB; k++) begin
        if (resp_pop && head.slot == SLOT_W'(k)) begin
          bank[k]  <= response_data;
          fresh[k] <= 1'b1;
        end else if (rd_slot == SW'(k)) begin
          fresh[k] <= 1'b0;
        end
      end
    end
  end

endmodule
